mem_bus_arbiter: RTL and testbench

Merges the core's instruction-fetch line bus (L1I miss path) and data line bus (L1D/store-queue miss and writeback path) onto one shared downstream memory channel. It sits between the core top level's `i_*`/`d_*` buses and the memory model or controller. Each request is tagged with its source, so every response returns to the requester that issued it. Per-source credit counters bound outstanding requests, and a registered request stage cuts the timing path to memory.

---
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-source (I/D) line-bus arbiter onto one memory channel with per-source credits.
// Requests: 1-cycle registered, stalls both sources while the output is held; responses: 0-cycle routed by tag, no buffering.
package Mem;
    typedef logic [31:0] lineaddr_t;
    typedef logic [63:0] line_t;
endpackage

module mem_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic                i_req_we,
    input  logic [ID_W-1:0]     i_req_id,
    input  Mem::lineaddr_t      i_req_addr,
    input  Mem::line_t          i_req_data,
    output logic                i_resp_valid,
    input  logic                i_resp_ready,
    output logic [ID_W-1:0]     i_resp_id,
    output Mem::line_t          i_resp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [ID_W-1:0]     d_req_id,
    input  Mem::lineaddr_t      d_req_addr,
    input  Mem::line_t          d_req_data,
    output logic                d_resp_valid,
    input  logic                d_resp_ready,
    output logic [ID_W-1:0]     d_resp_id,
    output Mem::line_t          d_resp_data,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic                m_req_we,
    output logic [ID_W:0]       m_req_id,
    output Mem::lineaddr_t      m_req_addr,
    output Mem::line_t          m_req_data,
    input  logic                m_resp_valid,
    output logic                m_resp_ready,
    input  logic [ID_W:0]       m_resp_id,
    input  Mem::line_t          m_resp_data
);
    localparam int   CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    logic [CNT_W-1:0] cnt_i, cnt_d;
    logic             out_valid;
    logic             last;
    logic             credit_i, credit_d, want_i, want_d, grant_i, grant_d;
    logic             can_load, req_hs_i, req_hs_d;
    logic             resp_src, resp_hs_i, resp_hs_d;

    assign credit_i = cnt_i < CNT_W'(MAX_OUTSTANDING);
    assign credit_d = cnt_d < CNT_W'(MAX_OUTSTANDING);
    assign want_i   = i_req_valid & credit_i;
    assign want_d   = d_req_valid & credit_d;
    assign grant_i  = want_i & (~want_d | (last == SRC_D));
    assign grant_d  = want_d & (~want_i | (last == SRC_I));
    assign can_load = ~out_valid | m_req_ready;

    // Gated by rst so nothing is accepted while reset holds the credit state cleared.
    assign i_req_ready = rst & can_load & credit_i & grant_i;
    assign d_req_ready = rst & can_load & credit_d & grant_d;
    assign req_hs_i    = i_req_valid & i_req_ready;
    assign req_hs_d    = d_req_valid & d_req_ready;

    assign m_req_valid = out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            m_req_we   <= 1'b0;
            m_req_id   <= '0;
            m_req_addr <= '0;
            m_req_data <= '0;
            last       <= SRC_D;
        end else if (req_hs_i) begin
            out_valid  <= 1'b1;
            m_req_we   <= i_req_we;
            m_req_id   <= {SRC_I, i_req_id};
            m_req_addr <= i_req_addr;
            m_req_data <= i_req_data;
            last       <= SRC_I;
        end else if (req_hs_d) begin
            out_valid  <= 1'b1;
            m_req_we   <= d_req_we;
            m_req_id   <= {SRC_D, d_req_id};
            m_req_addr <= d_req_addr;
            m_req_data <= d_req_data;
            last       <= SRC_D;
        end else if (m_req_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign resp_src     = m_resp_id[ID_W];
    assign i_resp_valid = m_resp_valid & (resp_src == SRC_I);
    assign d_resp_valid = m_resp_valid & (resp_src == SRC_D);
    assign i_resp_id    = m_resp_id[ID_W-1:0];
    assign d_resp_id    = m_resp_id[ID_W-1:0];
    assign i_resp_data  = m_resp_data;
    assign d_resp_data  = m_resp_data;
    assign m_resp_ready = (resp_src == SRC_D) ? d_resp_ready : i_resp_ready;
    assign resp_hs_i    = i_resp_valid & i_resp_ready;
    assign resp_hs_d    = d_resp_valid & d_resp_ready;

    // A response to a source with nothing outstanding is forwarded but cannot underflow the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_i <= '0;
            cnt_d <= '0;
        end else begin
            if (req_hs_i && !resp_hs_i)
                cnt_i <= cnt_i + CNT_W'(1);
            else if (!req_hs_i && resp_hs_i && cnt_i != '0)
                cnt_i <= cnt_i - CNT_W'(1);
            if (req_hs_d && !resp_hs_d)
                cnt_d <= cnt_d + CNT_W'(1);
            else if (!req_hs_d && resp_hs_d && cnt_d != '0)
                cnt_d <= cnt_d - CNT_W'(1);
        end
    end

    a_resp_i_no_outstanding: assert property (@(posedge clk) disable iff (!rst) resp_hs_i |-> cnt_i != '0);
    a_resp_d_no_outstanding: assert property (@(posedge clk) disable iff (!rst) resp_hs_d |-> cnt_d != '0);
    a_cnt_i_overflow: assert property (@(posedge clk) disable iff (!rst)
        (req_hs_i && !resp_hs_i) |-> cnt_i != CNT_W'(MAX_OUTSTANDING));
    a_cnt_d_overflow: assert property (@(posedge clk) disable iff (!rst)
        (req_hs_d && !resp_hs_d) |-> cnt_d != CNT_W'(MAX_OUTSTANDING));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against a credit/queue reference model.
module tb_mem_bus_arbiter;
    localparam int ID_W = 2;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_req_valid, i_req_ready, i_req_we;
    logic [ID_W-1:0] i_req_id;
    Mem::lineaddr_t i_req_addr;
    Mem::line_t i_req_data;
    logic i_resp_valid, i_resp_ready;
    logic [ID_W-1:0] i_resp_id;
    Mem::line_t i_resp_data;
    logic d_req_valid, d_req_ready, d_req_we;
    logic [ID_W-1:0] d_req_id;
    Mem::lineaddr_t d_req_addr;
    Mem::line_t d_req_data;
    logic d_resp_valid, d_resp_ready;
    logic [ID_W-1:0] d_resp_id;
    Mem::line_t d_resp_data;
    logic m_req_valid, m_req_ready, m_req_we;
    logic [ID_W:0] m_req_id;
    Mem::lineaddr_t m_req_addr;
    Mem::line_t m_req_data;
    logic m_resp_valid, m_resp_ready;
    logic [ID_W:0] m_resp_id;
    Mem::line_t m_resp_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_we(i_req_we),
        .i_req_id(i_req_id), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
        .i_resp_id(i_resp_id), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_id(d_req_id), .d_req_addr(d_req_addr), .d_req_data(d_req_data),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_id(d_resp_id), .d_resp_data(d_resp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_id(m_req_id), .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_resp_id(m_resp_id), .m_resp_data(m_resp_data)
    );

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_id = '0; i_req_addr = '0; i_req_data = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_id = '0; d_req_addr = '0; d_req_data = '0;
        i_resp_ready = 1'b1; d_resp_ready = 1'b1; m_req_ready = 1'b1;
        m_resp_valid = 1'b0; m_resp_id = '0; m_resp_data = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (m_req_valid !== 1'b0) $display("FAIL reset_m_req_valid: got %b want 0", m_req_valid); else passed++;
        total++; if (m_req_id !== 3'b000) $display("FAIL reset_m_req_id: got %h want 0", m_req_id); else passed++;
        total++; if (m_req_addr !== 32'h0) $display("FAIL reset_m_req_addr: got %h want 0", m_req_addr); else passed++;
        total++; if (m_req_data !== 64'h0 || m_req_we !== 1'b0)
            $display("FAIL reset_m_req_data_we: got %h/%b want 0/0", m_req_data, m_req_we); else passed++;
        total++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0)
            $display("FAIL reset_req_ready: got i=%b d=%b want 0/0", i_req_ready, d_req_ready); else passed++;
        total++; if (int'(dut.cnt_i) != 0 || int'(dut.cnt_d) != 0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0", dut.cnt_i, dut.cnt_d); else passed++;
        idle_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        i_req_valid = 1'b1; i_req_id = 2'd1; i_req_addr = 32'h10; i_req_we = 1'b0;
        @(negedge clk);
        total++; if (i_req_ready !== 1'b1) $display("FAIL single_i_ready: got %b want 1", i_req_ready); else passed++;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        total++; if (m_req_valid !== 1'b1) $display("FAIL single_m_valid: got %b want 1", m_req_valid); else passed++;
        total++; if (m_req_id !== 3'b001) $display("FAIL single_m_id: got %b want 001", m_req_id); else passed++;
        total++; if (m_req_addr !== 32'h10) $display("FAIL single_m_addr: got %h want 10", m_req_addr); else passed++;
        total++; if (int'(dut.cnt_i) != 1) $display("FAIL single_cnt_up: got %0d want 1", dut.cnt_i); else passed++;
        @(posedge clk); #1;
        m_resp_valid = 1'b1; m_resp_id = 3'b001; m_resp_data = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        total++; if (i_resp_valid !== 1'b1 || d_resp_valid !== 1'b0)
            $display("FAIL single_resp_route: got i=%b d=%b want 1/0", i_resp_valid, d_resp_valid); else passed++;
        total++; if (i_resp_id !== 2'd1) $display("FAIL single_resp_id: got %0d want 1", i_resp_id); else passed++;
        total++; if (i_resp_data !== 64'h1234_5678_9ABC_DEF0)
            $display("FAIL single_resp_data: got %h want 123456789abcdef0", i_resp_data); else passed++;
        total++; if (m_resp_ready !== 1'b1) $display("FAIL single_m_resp_ready: got %b want 1", m_resp_ready); else passed++;
        total++; if (m_req_valid !== 1'b0) $display("FAIL single_out_clear: got %b want 0", m_req_valid); else passed++;
        @(posedge clk); #1;
        m_resp_valid = 1'b0;
        @(negedge clk);
        total++; if (int'(dut.cnt_i) != 0) $display("FAIL single_cnt_down: got %0d want 0", dut.cnt_i); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        i_req_addr = $urandom; d_req_addr = $urandom;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin i_req_valid = 1'b0; d_req_valid = 1'b0; end
            @(negedge clk);
            total++; if (m_req_valid !== 1'b1 || m_req_id[ID_W] !== k[0])
                $display("FAIL alt_src_%0d: got v=%b src=%b want v=1 src=%b", k, m_req_valid, m_req_id[ID_W], k[0]);
            else passed++;
        end
    endtask

    task automatic test_credit();
        do_reset();
        d_req_valid = 1'b1; d_req_id = 2'd2;
        for (int k = 0; k < MAXO; k++) begin
            @(negedge clk);
            total++; if (d_req_ready !== 1'b1) $display("FAIL credit_accept_%0d: got %b want 1", k, d_req_ready); else passed++;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b1;
        @(negedge clk);
        total++; if (d_req_ready !== 1'b0) $display("FAIL credit_exhausted: got %b want 0", d_req_ready); else passed++;
        total++; if (i_req_ready !== 1'b1) $display("FAIL credit_i_flows: got %b want 1", i_req_ready); else passed++;
        total++; if (int'(dut.cnt_d) != MAXO) $display("FAIL credit_cnt_full: got %0d want %0d", dut.cnt_d, MAXO); else passed++;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        m_resp_valid = 1'b1; m_resp_id = 3'b110;
        @(negedge clk);
        total++; if (d_resp_valid !== 1'b1 || d_resp_id !== 2'd2)
            $display("FAIL credit_resp_route: got v=%b id=%0d want 1/2", d_resp_valid, d_resp_id); else passed++;
        total++; if (d_req_ready !== 1'b0) $display("FAIL credit_same_cycle: got %b want 0", d_req_ready); else passed++;
        @(posedge clk); #1;
        m_resp_valid = 1'b0;
        @(negedge clk);
        total++; if (d_req_ready !== 1'b1) $display("FAIL credit_next_cycle: got %b want 1", d_req_ready); else passed++;
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        @(negedge clk);
        total++; if (m_req_valid !== 1'b1 || m_req_id !== 3'b110)
            $display("FAIL credit_fifth_req: got v=%b id=%b want 1/110", m_req_valid, m_req_id); else passed++;
    endtask

    task automatic test_stall();
        int xfers;
        do_reset();
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_id = 2'd2; d_req_addr = 32'h22;
        d_req_data = 64'hABAB_ABAB_ABAB_ABAB;
        @(negedge clk);
        total++; if (d_req_ready !== 1'b1) $display("FAIL stall_load: got %b want 1", d_req_ready); else passed++;
        @(posedge clk); #1;
        d_req_addr = 32'h33; d_req_data = 64'h5555; d_req_we = 1'b0;
        i_req_valid = 1'b1; m_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h22 || m_req_data !== 64'hABAB_ABAB_ABAB_ABAB ||
                         m_req_we !== 1'b1 || m_req_id !== 3'b110)
                $display("FAIL stall_hold_%0d: got v=%b a=%h d=%h we=%b id=%b want 1/22/abab.../1/110",
                         k, m_req_valid, m_req_addr, m_req_data, m_req_we, m_req_id);
            else passed++;
            total++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0)
                $display("FAIL stall_ready_%0d: got i=%b d=%b want 0/0", k, i_req_ready, d_req_ready); else passed++;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0; m_req_ready = 1'b1;
        xfers = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_req_valid && m_req_ready) xfers++;
            @(posedge clk); #1;
        end
        total++; if (xfers != 1) $display("FAIL stall_release_xfers: got %0d want 1", xfers); else passed++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        d_req_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_resp_valid = 1'b1; m_resp_id = 3'b101;
        @(negedge clk);
        total++; if (int'(dut.cnt_d) != 2) $display("FAIL same_pre_cnt: got %0d want 2", dut.cnt_d); else passed++;
        total++; if (d_req_ready !== 1'b1 || m_resp_ready !== 1'b1)
            $display("FAIL same_both_hs: got req_rdy=%b resp_rdy=%b want 1/1", d_req_ready, m_resp_ready); else passed++;
        @(posedge clk); #1;
        d_req_valid = 1'b0; d_resp_ready = 1'b0;
        @(negedge clk);
        total++; if (int'(dut.cnt_d) != 2) $display("FAIL same_cnt_hold: got %0d want 2", dut.cnt_d); else passed++;
        total++; if (m_resp_ready !== 1'b0 || d_resp_valid !== 1'b1)
            $display("FAIL same_resp_stall: got rdy=%b v=%b want 0/1", m_resp_ready, d_resp_valid); else passed++;
        @(posedge clk); #1;
        m_resp_valid = 1'b0; d_resp_ready = 1'b1;
        @(negedge clk);
        total++; if (int'(dut.cnt_d) != 2) $display("FAIL same_cnt_stalled: got %0d want 2", dut.cnt_d); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_req_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        i_req_valid = 1'b0;
        #2;
        total++; if (int'(dut.cnt_i) != 3 || m_req_valid !== 1'b1)
            $display("FAIL mid_pre: got cnt=%0d v=%b want 3/1", dut.cnt_i, m_req_valid); else passed++;
        rst = 1'b0;
        #1;
        total++; if (int'(dut.cnt_i) != 0 || int'(dut.cnt_d) != 0 || m_req_valid !== 1'b0)
            $display("FAIL mid_async: got cnt_i=%0d cnt_d=%0d v=%b want 0/0/0", dut.cnt_i, dut.cnt_d, m_req_valid);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        @(negedge clk);
        total++; if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0)
            $display("FAIL mid_first_tie: got i=%b d=%b want 1/0", i_req_ready, d_req_ready); else passed++;
        @(posedge clk); #1;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        total++; if (m_req_valid !== 1'b1 || m_req_id[ID_W] !== 1'b0)
            $display("FAIL mid_first_src: got v=%b src=%b want 1/0", m_req_valid, m_req_id[ID_W]); else passed++;
    endtask

    task automatic test_random();
        int oi, od, lst, kk;
        bit ov, rv, eri, erd, emr, sel;
        logic [ID_W:0] pend[$];
        logic [ID_W:0] e_id;
        Mem::lineaddr_t e_addr;
        Mem::line_t e_data;
        logic e_we;
        do_reset();
        oi = 0; od = 0; lst = 1; ov = 1'b0; kk = 0;
        e_id = '0; e_addr = '0; e_data = '0; e_we = 1'b0;
        for (int c = 0; c < 500; c++) begin
            i_req_valid = ($urandom % 3) != 0; i_req_we = $urandom; i_req_id = 2'($urandom);
            i_req_addr = $urandom; i_req_data = {$urandom, $urandom};
            d_req_valid = ($urandom % 3) != 0; d_req_we = $urandom; d_req_id = 2'($urandom);
            d_req_addr = $urandom; d_req_data = {$urandom, $urandom};
            m_req_ready = ($urandom % 4) != 0;
            i_resp_ready = ($urandom % 4) != 0; d_resp_ready = ($urandom % 4) != 0;
            rv = pend.size() > 0 && ($urandom % 2) == 1;
            if (rv) begin
                kk = $urandom_range(0, pend.size() - 1);
                m_resp_id = pend[kk];
            end else begin
                m_resp_id = 3'($urandom);
            end
            m_resp_valid = rv;
            m_resp_data = {$urandom, $urandom};
            @(negedge clk);
            // A source may be picked only with credit, preferring the one not served last on a tie.
            eri = 1'b0; erd = 1'b0;
            if (!ov || m_req_ready) begin
                if (i_req_valid && oi < MAXO && (!(d_req_valid && od < MAXO) || lst == 1)) eri = 1'b1;
                else if (d_req_valid && od < MAXO) erd = 1'b1;
            end
            sel = m_resp_id[ID_W];
            emr = sel ? d_resp_ready : i_resp_ready;
            total++; if (i_req_ready !== eri || d_req_ready !== erd)
                $display("FAIL rnd_ready c%0d: got i=%b d=%b want %b/%b", c, i_req_ready, d_req_ready, eri, erd);
            else passed++;
            total++; if (m_req_valid !== ov) $display("FAIL rnd_m_valid c%0d: got %b want %b", c, m_req_valid, ov); else passed++;
            if (ov) begin
                total++; if (m_req_id !== e_id || m_req_addr !== e_addr || m_req_data !== e_data || m_req_we !== e_we)
                    $display("FAIL rnd_payload c%0d: got %b/%h/%h/%b want %b/%h/%h/%b", c, m_req_id, m_req_addr,
                             m_req_data, m_req_we, e_id, e_addr, e_data, e_we);
                else passed++;
            end
            total++; if (i_resp_valid !== (rv && !sel) || d_resp_valid !== (rv && sel) || m_resp_ready !== emr)
                $display("FAIL rnd_resp c%0d: got iv=%b dv=%b rdy=%b want %b/%b/%b", c, i_resp_valid, d_resp_valid,
                         m_resp_ready, rv && !sel, rv && sel, emr);
            else passed++;
            if (rv) begin
                total++; if ((sel ? d_resp_id : i_resp_id) !== m_resp_id[ID_W-1:0] ||
                             (sel ? d_resp_data : i_resp_data) !== m_resp_data)
                    $display("FAIL rnd_resp_payload c%0d: got id=%0d want %0d", c,
                             sel ? d_resp_id : i_resp_id, m_resp_id[ID_W-1:0]);
                else passed++;
            end
            total++; if (int'(dut.cnt_i) != oi || int'(dut.cnt_d) != od)
                $display("FAIL rnd_counts c%0d: got %0d/%0d want %0d/%0d", c, dut.cnt_i, dut.cnt_d, oi, od);
            else passed++;
            if (rv && emr) begin
                pend.delete(kk);
                if (sel) od--; else oi--;
            end
            if (ov && m_req_ready) pend.push_back(e_id);
            if (eri) begin
                ov = 1'b1; e_id = {1'b0, i_req_id}; e_addr = i_req_addr; e_data = i_req_data; e_we = i_req_we;
                lst = 0; oi++;
            end else if (erd) begin
                ov = 1'b1; e_id = {1'b1, d_req_id}; e_addr = d_req_addr; e_data = d_req_data; e_we = d_req_we;
                lst = 1; od++;
            end else if (m_req_ready) begin
                ov = 1'b0;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_credit();
        test_stall();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
